// File: rtl/aes_mmio_bridge.sv
// MMIO bridge between the execute-stage data port and an AES-128 core: eight staging words,
// a command register, a request/response FSM and a zero-latency read mux. Optional IRQ: AES_BRIDGE_IRQ_EN.
module aes_mmio_bridge (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic         cpu_we,
    input  logic         cpu_re,
    output logic [31:0]  cpu_rdata,
    output logic         aes_in_valid,
    input  logic         aes_in_ready,
    output logic [127:0] aes_plaintext,
    output logic [127:0] aes_key,
    input  logic         aes_out_valid,
    input  logic [127:0] aes_ciphertext
`ifdef AES_BRIDGE_IRQ_EN
    ,
    output logic         aes_irq
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FLUSH = 3'd4
    } bridgeState_e;

    bridgeState_e stateReg, stateNext;

    logic [3:0]   wPtrReg;
    logic [1:0]   rPtrReg;
    logic         errReg;
    logic         doneReg;
    logic         rselReg;
    logic         abortReg;
    logic [255:0] stageBus;
    logic [127:0] resultBus;

    logic        isData, isCmd, dataWr, cmdWr, cmdClear, cmdStart;
    logic        inIdle, full, stageWrOk, startOk, popEn, lastPop, capture, busy;
    logic [31:0] statusWord;

    assign isData    = (cpu_addr[31:2] == 30'd14);
    assign isCmd     = (cpu_addr == 32'd77);
    assign dataWr    = cpu_we && isData;
    assign cmdWr     = cpu_we && isCmd;
    assign cmdClear  = cmdWr && cpu_wdata[1];
    // CLEAR outranks START when both bits are written together.
    assign cmdStart  = cmdWr && cpu_wdata[0] && !cpu_wdata[1];
    assign inIdle    = (stateReg == IDLE);
    assign full      = (wPtrReg == 4'd8);
    assign stageWrOk = dataWr && inIdle && (wPtrReg < 4'd8);
    assign startOk   = cmdStart && inIdle && full;
    assign popEn     = cpu_re && isData && rselReg && (stateReg == DONE);
    assign lastPop   = popEn && (rPtrReg == 2'd3);
    assign capture   = (stateReg == WAIT) && aes_out_valid && !cmdClear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        aes_in_valid = 1'b0;
        busy         = 1'b0;
        case (stateReg)
            IDLE: begin
                if (startOk) stateNext = REQ;
            end
            REQ: begin
                aes_in_valid = 1'b1;
                busy         = 1'b1;
                // The request is never withdrawn; an abort only redirects the post-handshake path.
                if (aes_in_ready) stateNext = (abortReg || cmdClear) ? FLUSH : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cmdClear)           stateNext = FLUSH;
                else if (aes_out_valid) stateNext = DONE;
            end
            DONE: begin
                if (cmdClear || lastPop) stateNext = IDLE;
            end
            FLUSH: begin
                busy = 1'b1;
                if (aes_out_valid) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wPtrReg  <= 4'd0;
            rPtrReg  <= 2'd0;
            errReg   <= 1'b0;
            doneReg  <= 1'b0;
            rselReg  <= 1'b0;
            abortReg <= 1'b0;
        end else begin
            if (cmdWr) rselReg <= cpu_wdata[2];

            if (cmdClear || lastPop)  wPtrReg <= 4'd0;
            else if (stageWrOk)       wPtrReg <= wPtrReg + 4'd1;

            if (cmdClear || lastPop)  rPtrReg <= 2'd0;
            else if (popEn)           rPtrReg <= rPtrReg + 2'd1;

            if (cmdClear || lastPop)  doneReg <= 1'b0;
            else if (capture)         doneReg <= 1'b1;

            if (cmdClear)
                errReg <= 1'b0;
            else if ((dataWr && !stageWrOk) || (cmdStart && !startOk))
                errReg <= 1'b1;

            if (stateReg == REQ) abortReg <= aes_in_ready ? 1'b0 : (abortReg || cmdClear);
            else                 abortReg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : gStage
            logic [31:0] wordReg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                                  wordReg <= '0;
                else if (stageWrOk && (wPtrReg[2:0] == 3'(gi))) wordReg <= cpu_wdata;
            end
            assign stageBus[32*gi +: 32] = wordReg;
        end

        for (gi = 0; gi < 4; gi++) begin : gResult
            logic [31:0] wordReg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)       wordReg <= '0;
                else if (capture) wordReg <= aes_ciphertext[32*gi +: 32];
            end
            assign resultBus[32*gi +: 32] = wordReg;
        end
    endgenerate

    assign aes_plaintext = stageBus[127:0];
    assign aes_key       = stageBus[255:128];

    assign statusWord = {23'b0, rPtrReg, wPtrReg, errReg, doneReg, busy};

    always_comb begin
        cpu_rdata = '0;
        if (isData) begin
            if (!rselReg)                cpu_rdata = statusWord;
            else if (stateReg == DONE)   cpu_rdata = resultBus[{rPtrReg, 5'b0} +: 32];
        end
    end

`ifdef AES_BRIDGE_IRQ_EN
    logic irqReg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 irqReg <= 1'b0;
        else if (cmdClear || popEn) irqReg <= 1'b0;
        else if (capture)           irqReg <= 1'b1;
    end
    assign aes_irq = irqReg;
`endif

endmodule

// File: tb/tb_aes_mmio_bridge.sv
// Scoreboard bench for aes_mmio_bridge: a behavioural register-file model predicts every load and
// every AES request; independent monitors compare them against the DUT; a responder plays the AES core.
module tb_aes_mmio_bridge;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  cpuAddr = '0;
    logic [31:0]  cpuWdata = '0;
    logic         cpuWe = 1'b0;
    logic         cpuRe = 1'b0;
    logic [31:0]  cpuRdata;
    logic         aesInValid;
    logic         aesInReady = 1'b0;
    logic [127:0] aesPlaintext;
    logic [127:0] aesKey;
    logic         aesOutValid = 1'b0;
    logic [127:0] aesCiphertext = '0;
`ifdef AES_BRIDGE_IRQ_EN
    logic         aesIrq;
`endif

    aes_mmio_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpuAddr),
        .cpu_wdata      (cpuWdata),
        .cpu_we         (cpuWe),
        .cpu_re         (cpuRe),
        .cpu_rdata      (cpuRdata),
        .aes_in_valid   (aesInValid),
        .aes_in_ready   (aesInReady),
        .aes_plaintext  (aesPlaintext),
        .aes_key        (aesKey),
        .aes_out_valid  (aesOutValid),
        .aes_ciphertext (aesCiphertext)
`ifdef AES_BRIDGE_IRQ_EN
        ,
        .aes_irq        (aesIrq)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0]  DATA_ADDR = 32'd56;
    localparam logic [31:0]  CMD_ADDR  = 32'd77;
    localparam logic [127:0] FIPS_PT   = {32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    localparam logic [127:0] FIPS_KEY  = {32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203};
    localparam logic [127:0] FIPS_CT   = {32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};

    int compared = 0;
    int mismatched = 0;

    logic [31:0]  rdQ[$];
    string        rdNameQ[$];
    logic [255:0] reqQ[$];

    // Behavioural model: software-visible register file of the bridge.
    logic [31:0]  mStage[8];
    int           mWptr, mRptr;
    bit           mErr, mDone, mBusy, mDiscard, mRsel, mIrq;
    logic [127:0] mResult, mPending;

    // Responder state
    int           readyWait = 0;
    int           respLatency = 10;
    int           respSent = 0;
    bit           spurious = 1'b0;
    bit           rPend = 1'b0, rHs = 1'b0;
    int           rCnt = 0, rWait = 0;
    logic [127:0] rPt, rKey, rCt;
    bit           prevPending = 1'b0;

    function automatic void check(input string name, input logic [255:0] got, input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Stand-in AES core: exact FIPS-197 answer for the reference vector, a keyed scramble otherwise.
    function automatic logic [127:0] aesFn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return {pt[95:0], pt[127:96]} ^ key ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9669_6996;
    endfunction

    function automatic void mReset();
        for (int i = 0; i < 8; i++) mStage[i] = '0;
        mWptr = 0; mRptr = 0; mErr = 0; mDone = 0; mBusy = 0; mDiscard = 0; mRsel = 0; mIrq = 0;
        mResult = '0; mPending = '0;
        reqQ.delete();
    endfunction

    function automatic void mDataStore(input logic [31:0] w);
        if (!mBusy && !mDone && mWptr < 8) begin
            mStage[mWptr] = w;
            mWptr++;
        end else begin
            mErr = 1;
        end
    endfunction

    function automatic void mCmd(input logic [31:0] w);
        logic [127:0] pt, key;
        mRsel = w[2];
        if (w[1]) begin
            mWptr = 0; mRptr = 0; mErr = 0; mIrq = 0;
            mDone = 0;
            if (mBusy) mDiscard = 1;
        end else if (w[0]) begin
            if (!mBusy && !mDone && mWptr == 8) begin
                pt  = {mStage[3], mStage[2], mStage[1], mStage[0]};
                key = {mStage[7], mStage[6], mStage[5], mStage[4]};
                mBusy = 1; mDiscard = 0;
                mPending = aesFn(pt, key);
                reqQ.push_back({key, pt});
            end else begin
                mErr = 1;
            end
        end
    endfunction

    function automatic logic [31:0] mLoad(input logic [31:0] a);
        logic [31:0] v;
        int s;
        v = '0;
        if ((a >> 2) != 32'd14) return '0;
        if (!mRsel) begin
            s = int'(mBusy) + 2 * int'(mDone) + 4 * int'(mErr) + 8 * mWptr + 128 * mRptr;
            return 32'(s);
        end
        if (mDone) begin
            v = 32'(mResult >> (32 * mRptr));
            mRptr++;
            mIrq = 0;
            if (mRptr == 4) begin
                mRptr = 0; mWptr = 0; mDone = 0;
            end
        end
        return v;
    endfunction

    function automatic void mResponse();
        if (mBusy) begin
            mBusy = 0;
            if (!mDiscard) begin
                mDone = 1;
                mResult = mPending;
                mIrq = 1;
            end
            mDiscard = 0;
        end
    endfunction

    task automatic cpuOp(input logic [31:0] a, input logic [31:0] w, input bit we, input bit re);
        cpuAddr = a; cpuWdata = w; cpuWe = we; cpuRe = re;
        @(posedge clk); #1;
        cpuAddr = '0; cpuWdata = '0; cpuWe = 1'b0; cpuRe = 1'b0;
    endtask

    task automatic dataStore(input logic [31:0] w);
        mDataStore(w);
        cpuOp(DATA_ADDR, w, 1'b1, 1'b0);
    endtask

    task automatic cmd(input logic [31:0] w);
        mCmd(w);
        cpuOp(CMD_ADDR, w, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [31:0] a, input string name);
        rdQ.push_back(mLoad(a));
        rdNameQ.push_back(name);
        cpuOp(a, '0, 1'b0, 1'b1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitResp(input string name);
        int target;
        bit got;
        target = respSent;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (respSent != target) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL %s_timeout: got no aes_out_valid expected one within 300 cycles", name);
        end
        @(posedge clk); #1;
        mResponse();
    endtask

    task automatic checkIrq(input string name);
`ifdef AES_BRIDGE_IRQ_EN
        check(name, 256'(aesIrq), 256'(mIrq));
`endif
    endtask

    task automatic fill8(input bit fips);
        for (int i = 0; i < 8; i++) begin
            if (fips) dataStore(i < 4 ? 32'(FIPS_PT >> (32 * i)) : 32'(FIPS_KEY >> (32 * (i - 4))));
            else      dataStore($urandom);
        end
    endtask

    // Load monitor: every load cycle pops one prediction.
    always @(negedge clk) begin
        if (cpuRe) begin
            if (rdQ.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_load: got rdata %0h expected no load", cpuRdata);
            end else begin
                check(rdNameQ.pop_front(), 256'(cpuRdata), 256'(rdQ.pop_front()));
            end
        end
    end

    // Request monitor: payload must match the predicted request on every valid cycle; pop on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            prevPending = 1'b0;
        end else begin
            if (prevPending && !aesInValid) begin
                compared++; mismatched++;
                $display("FAIL req_dropped: got aes_in_valid 0 expected 1 before handshake");
            end
            if (aesInValid) begin
                if (reqQ.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_req: got aes_in_valid 1 expected 0");
                end else begin
                    check("req_payload", {aesKey, aesPlaintext}, reqQ[0]);
                    if (aesInReady) void'(reqQ.pop_front());
                end
            end
            prevPending = aesInValid && !aesInReady;
        end
    end

    // AES responder: ready after readyWait valid cycles, one-cycle result respLatency cycles later.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                rPend = 0; rHs = 0; rCnt = 0; rWait = 0;
                aesInReady = 1'b0; aesOutValid = 1'b0;
                continue;
            end
            aesOutValid = 1'b0;
            if (rHs) begin
                rPend = 1; rCnt = respLatency; rCt = aesFn(rPt, rKey);
            end
            if (rPend) begin
                if (rCnt <= 1) begin
                    aesOutValid = 1'b1; aesCiphertext = rCt; rPend = 0; respSent++;
                end else begin
                    rCnt--;
                end
            end else if (spurious) begin
                aesOutValid = 1'b1;
                aesCiphertext = {$urandom, $urandom, $urandom, $urandom};
                spurious = 0;
                respSent++;
            end
            if (aesInValid) begin
                rWait++;
                aesInReady = (rWait > readyWait);
            end else begin
                rWait = 0;
                aesInReady = 1'b0;
            end
            rHs = aesInValid && aesInReady;
            rPt = aesPlaintext;
            rKey = aesKey;
            if (rHs) rWait = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rselBit;
        int n, act;
        mReset();

        // Reset values
        cpuAddr = DATA_ADDR;
        #1;
        check("rst_in_valid", 256'(aesInValid), 256'(0));
        check("rst_rdata", 256'(cpuRdata), 256'(0));
        check("rst_pt_key", {aesKey, aesPlaintext}, 256'(0));
        checkIrq("rst_irq");
        cpuAddr = '0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        load(DATA_ADDR, "status_after_reset");

        // FIPS-197 vector end to end
        fill8(1'b1);
        readyWait = 0;
        cmd(32'h1);
        check("valid_after_start", 256'(aesInValid), 256'(1));
        waitResp("fips");
        checkIrq("irq_after_capture");
        cmd(32'h4);
        load(DATA_ADDR, "fips_ct0");
        checkIrq("irq_after_pop");
        load(DATA_ADDR, "fips_ct1");
        load(DATA_ADDR, "fips_ct2");
        load(DATA_ADDR, "fips_ct3");
        load(DATA_ADDR, "data_after_drain");
        cmd(32'h0);
        load(DATA_ADDR, "status_after_drain");

        // Early START after 5 stores
        cmd(32'h2);
        for (int i = 0; i < 5; i++) dataStore($urandom);
        cmd(32'h1);
        check("early_start_no_valid", 256'(aesInValid), 256'(0));
        load(DATA_ADDR, "status_early_start");

        // Held request: ready low for 6 valid cycles
        cmd(32'h2);
        fill8(1'b0);
        readyWait = 6;
        cmd(32'h1);
        for (int i = 0; i < 6; i++) begin
            check("held_valid", 256'(aesInValid), 256'(1));
            idleCycles(1);
        end
        waitResp("held");
        cmd(32'h2);

        // DATA store during REQ, then a 9th store when full
        fill8(1'b0);
        readyWait = 3;
        cmd(32'h1);
        dataStore(32'hdeadbeef);
        load(DATA_ADDR, "status_store_busy");
        waitResp("store_busy");
        cmd(32'h2);
        fill8(1'b0);
        dataStore(32'hcafef00d);
        load(DATA_ADDR, "status_ninth_store");
        cmd(32'h2);

        // Abort in WAIT
        fill8(1'b0);
        readyWait = 0;
        cmd(32'h1);
        idleCycles(3);
        cmd(32'h2);
        load(DATA_ADDR, "status_flush");
        waitResp("abort");
        load(DATA_ADDR, "status_after_flush");
        cmd(32'h4);
        load(DATA_ADDR, "data_after_abort");

        // Reset while in DONE, then a stray aes_out_valid
        cmd(32'h2);
        fill8(1'b0);
        cmd(32'h1);
        waitResp("pre_reset");
        cpuAddr = DATA_ADDR;
        #2 reset = 1'b0;
        #1;
        check("reset_done_rdata", 256'(cpuRdata), 256'(0));
        check("reset_done_valid", 256'(aesInValid), 256'(0));
        check("reset_done_pt_key", {aesKey, aesPlaintext}, 256'(0));
        checkIrq("reset_done_irq");
        cpuAddr = '0;
        mReset();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b1;
        idleCycles(4);
        load(DATA_ADDR, "status_after_stray");
        cmd(32'h4);
        load(DATA_ADDR, "data_after_stray");

        // Randomized sessions
        for (int it = 0; it < 40; it++) begin
            cmd(32'h2);
            n = $urandom_range(0, 10);
            for (int k = 0; k < n; k++) dataStore($urandom);
            if ($urandom_range(0, 1) == 1) load(DATA_ADDR, "rnd_status_fill");
            if ($urandom_range(0, 3) == 0) load(32'h0000_0100 + 32'($urandom_range(0, 15) * 4), "rnd_nondata");
            if ($urandom_range(0, 3) == 0) load(CMD_ADDR, "rnd_cmd_addr");
            readyWait = $urandom_range(0, 4);
            rselBit = 1'($urandom_range(0, 1));
            cmd(32'h1 | {29'b0, rselBit, 2'b0});
            if (mBusy) begin
                act = $urandom_range(0, 3);
                if (act == 1) dataStore($urandom);
                if (act == 2) begin
                    idleCycles($urandom_range(0, 3));
                    cmd(32'h2 | {29'b0, rselBit, 2'b0});
                end
                if (!rselBit) load(DATA_ADDR, "rnd_status_busy");
                waitResp("rnd");
                if (mDone) begin
                    checkIrq("rnd_irq_set");
                    cmd(32'h4);
                    for (int k = 0; k < 4; k++) begin
                        load(DATA_ADDR, "rnd_ct_word");
                        checkIrq("rnd_irq_pop");
                    end
                end
            end
            cmd(32'h0);
            load(DATA_ADDR, "rnd_status_end");
        end

        idleCycles(2);
        check("rdq_drained", 256'(rdQ.size()), 256'(0));
        check("reqq_drained", 256'(reqQ.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_mmio_bridge.md
# aes_mmio_bridge

Memory-mapped bridge between the 6-stage RISC-V core's execute-stage data port and an AES-128 encryption core. It consumes the core's ALU address, store data and store strobe, and produces the 32-bit `aes_read` word that the core pipelines into write-back for loads from word address 14.

Software loads eight 32-bit words (plaintext, then key), issues a start command and reads back four ciphertext words. The AES side uses a valid/ready request and a valid-only response.

## Interface
- No parameters.
- `clk  input  1` – single clock; all state updates on the rising edge.
- `reset  input  1` – asynchronous, active-low reset.
- `cpu_addr  input  32` – byte address from the execute stage (`ALUResultX`).
- `cpu_wdata  input  32` – store data (`RD2X`).
- `cpu_we  input  1` – store strobe (`MemWriteX`).
- `cpu_re  input  1` – load strobe, asserted for load instructions in execute.
- `cpu_rdata  output  32` – read word, connected to `aes_read`.
- `aes_in_valid  output  1` – encryption request valid.
- `aes_in_ready  input  1` – AES core accepts the request.
- `aes_plaintext  output  128` – staging words 3..0; word 0 is bits [31:0].
- `aes_key  output  128` – staging words 7..4; word 4 is bits [31:0].
- `aes_out_valid  input  1` – one-cycle result strobe.
- `aes_ciphertext  input  128` – result, sampled when `aes_out_valid` is high.
- `aes_irq  output  1` – present only with `AES_BRIDGE_IRQ_EN`.

## Operation
- **Address decode**
  - DATA: `cpu_addr[31:2]==14`.
  - CMD: `cpu_addr==77`; store only.
- **DATA store** (`cpu_we`) in IDLE with `wptr<8`:
  - writes `stage[wptr]`, then `wptr++`.
  - `full` = (`wptr==8`); `wptr` is 4 bits.
  - A DATA store while `full` or not in IDLE is dropped and sets `err`.
- **CMD store**
  - `cpu_wdata[0]` START: accepted only in IDLE with `full`; otherwise it sets `err`.
  - `cpu_wdata[1]` CLEAR: `wptr=0`, `rptr=0`, `err=0`, `done=0`.
  - `cpu_wdata[2]` RSEL: latched every CMD store; 0 selects status reads, 1 selects data reads.
  - CLEAR together with START: CLEAR wins and START is ignored.
- **FSM states**
  - IDLE: START goes to REQ.
  - REQ: `aes_in_valid=1`. On `aes_in_ready`, go to WAIT, or to FLUSH if a CLEAR occurred while in REQ (`abort` flag). `aes_in_valid` is never dropped before the handshake.
  - WAIT: on `aes_out_valid`, capture `aes_ciphertext` into `result`, set `done`, go to DONE. A CLEAR in WAIT goes to FLUSH.
  - DONE: a data-mode DATA load (`cpu_re`, RSEL=1) returns `result[rptr]` and `rptr++`. After `rptr==3` is read, go to IDLE with `done=0`, `wptr=0`, `rptr=0`. CLEAR in DONE goes to IDLE.
  - FLUSH: `aes_out_valid` goes to IDLE; the result is discarded.
- **Read mux**
  - `cpu_rdata` is combinational from `cpu_addr` and registered state.
  - Status mode: `{23'b0, rptr[1:0], wptr[3:0], err, done, busy}`; `busy` = REQ|WAIT|FLUSH. Status reads have no side effects.
  - Data mode outside DONE returns 0 with no side effect.
  - Non-DATA addresses return 0.
- `aes_in_valid` with `aes_out_valid` in the same cycle: each is handled by its own state rule; `aes_out_valid` outside WAIT/FLUSH is ignored.

## Timing
- Reset values:
  - state IDLE; `wptr`, `rptr`, `err`, `done`, RSEL, `abort` = 0; `stage` and `result` = 0.
  - Outputs: `aes_in_valid=0`, `cpu_rdata=0`, `aes_plaintext=0`, `aes_key=0`, `aes_irq=0`.
- Asserting reset mid-operation returns to IDLE immediately. A later `aes_out_valid` is ignored in IDLE.
- `cpu_rdata` has zero latency: it is valid in the same cycle `cpu_addr` is presented. The core adds two register stages to reach write-back.
- A pop takes effect on the edge ending the load's execute cycle. Back-to-back loads read consecutive words.
- START store at edge N: `aes_in_valid` is high from cycle N+1.
- Capture at the edge where `aes_out_valid` is high. `done`/DONE are visible the next cycle.
- `aes_plaintext` and `aes_key` are stable from START through WAIT, because DATA stores outside IDLE are dropped.

## Configuration
- `AES_BRIDGE_IRQ_EN` defined:
  - `aes_irq` is a registered output, set on entry to DONE.
  - Cleared by the first data-mode pop, by CLEAR, or by reset.
- Not defined: the `aes_irq` port and its logic are absent, and completion is polled through the `done` status bit.

## Test plan
- **Full encryption:** 8 DATA stores of the FIPS-197 vector (key 000102..0f, pt 00112233..ff), START, AES model answers after 10 cycles, RSEL=1, 4 loads → 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a in word order 0..3; then IDLE with status 0.
- **Early START:** START after 5 DATA stores → no `aes_in_valid`; status reads `wptr=5`, `err=1`.
- **Held request:** `aes_in_ready` held low for 6 cycles → `aes_in_valid` stays high and `aes_plaintext` is stable until the handshake.
- **Abort:** CLEAR during WAIT → FLUSH with `busy=1`; on `aes_out_valid` → IDLE, `done=0`, ciphertext not readable (data read returns 0).
- **Store while busy:** DATA store during REQ → `stage` unchanged, `err=1`; a 9th store when `full` → also sets `err`.
- **Reset and IRQ:** reset asserted in DONE → all outputs 0. Separately, with `AES_BRIDGE_IRQ_EN`: `aes_irq` rises one cycle after capture and falls after the first pop.
